// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       stop_err;
    } rx_entry_t;

    function automatic rx_entry_t make_rx_entry(input logic [7:0] data,
                                                input logic       parity_err,
                                                input logic       stop_err);
        rx_entry_t e;
        e.data       = data;
        e.parity_err = parity_err;
        e.stop_err   = stop_err;
        return e;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array of received characters: one synchronous write port, one
// combinational read port, cleared by synchronous reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  rx_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output rx_entry_t       rdata_o
);

    rx_entry_t [DEPTH-1:0] mem_q;
    rx_entry_t [DEPTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with sticky
// overrun, threshold interrupt and optional RTS (UART_RX_FIFO_RTS_EN).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_parity_err_i,
    input  logic          rx_stop_err_i,
    input  logic          rd_en_i,
    input  logic          flush_i,
    input  logic [AW:0]   threshold_i,
    input  logic          overrun_clr_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_parity_err_o,
    output logic          rd_stop_err_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          thresh_irq_o,
    output logic          overrun_o,
    output logic          rts_no
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic          rx_valid_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          thresh_irq_q, thresh_irq_d;

    logic          push, pop, wr_en, drop, empty, full;
    rx_entry_t     wr_entry, head;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DepthCnt);
        push  = rx_valid_i & ~rx_valid_q;
        pop   = rd_en_i & ~empty & ~flush_i;
        // A pop in the same cycle frees the slot the full-FIFO push lands in.
        wr_en = push & (~full | pop) & ~flush_i;
        drop  = push & full & ~pop & ~flush_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_en && !pop) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (!wr_en && pop) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end

        // Set beats clear when both land in one cycle.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        thresh_irq_d = (threshold_i != '0) && (count_q >= threshold_i);
    end

    // Edge detector is reloaded during reset so a level already high is not a push.
    always_ff @(posedge clk) begin
        rx_valid_q <= rx_valid_i;
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            thresh_irq_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            thresh_irq_q <= thresh_irq_d;
        end
    end

`ifdef UART_RX_FIFO_RTS_EN
    localparam logic [AW:0] RtsLevel = (AW + 1)'(DEPTH - 2);

    logic rts_q, rts_d;

    always_comb begin
        rts_d = (count_q >= RtsLevel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= rts_d;
        end
    end

    assign rts_no = rts_q;
`else
    assign rts_no = 1'b0;
`endif

    assign wr_entry = make_rx_entry(rx_data_i, rx_parity_err_i, rx_stop_err_i);

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign rd_data_o       = head.data;
    assign rd_parity_err_o = head.parity_err;
    assign rd_stop_err_o   = head.stop_err;
    assign empty_o         = empty;
    assign full_o          = full;
    assign count_o         = count_q;
    assign thresh_irq_o    = thresh_irq_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef UART_RX_FIFO_RTS_EN
    localparam bit RtsEn = 1'b1;
`else
    localparam bit RtsEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, rx_valid, rx_perr, rx_serr, rd_en, flush, ovclr;
    logic [7:0]    rx_data;
    logic [AW:0]   thr;
    logic [7:0]    rd_data_o;
    logic          rd_parity_err_o, rd_stop_err_o, empty_o, full_o;
    logic [AW:0]   count_o;
    logic          thresh_irq_o, overrun_o, rts_no;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [9:0] mq[$];
    bit         m_prev, m_overrun, m_thr, m_rts;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid_i      (rx_valid),
        .rx_data_i       (rx_data),
        .rx_parity_err_i (rx_perr),
        .rx_stop_err_i   (rx_serr),
        .rd_en_i         (rd_en),
        .flush_i         (flush),
        .threshold_i     (thr),
        .overrun_clr_i   (ovclr),
        .rd_data_o       (rd_data_o),
        .rd_parity_err_o (rd_parity_err_o),
        .rd_stop_err_o   (rd_stop_err_o),
        .empty_o         (empty_o),
        .full_o          (full_o),
        .count_o         (count_o),
        .thresh_irq_o    (thresh_irq_o),
        .overrun_o       (overrun_o),
        .rts_no          (rts_no)
    );

    task automatic model_update();
        int old;
        bit push, pop, ovset;
        old = mq.size();
        if (reset) begin
            mq.delete();
            m_overrun = 0;
            m_thr     = 0;
            m_rts     = 0;
            m_prev    = rx_valid;
            return;
        end
        push   = rx_valid && !m_prev;
        m_prev = rx_valid;
        m_thr  = (thr != 0) && (old >= int'(thr));
        m_rts  = RtsEn && (old >= DEPTH - 2);
        ovset  = 0;
        if (flush) begin
            mq.delete();
        end else begin
            pop = rd_en && (old > 0);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (old < DEPTH || pop) mq.push_back({rx_data, rx_perr, rx_serr});
                else ovset = 1;
            end
        end
        if (ovset) m_overrun = 1;
        else if (ovclr) m_overrun = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_char(input logic [7:0] d, input logic p, input logic s);
        rx_valid = 1'b1; rx_data = d; rx_perr = p; rx_serr = s;
        step();
        rx_valid = 1'b0;
        step();
    endtask

    task automatic pop_char();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full_o); end
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun_o); end
        checks++; if (thresh_irq_o !== 1'b0) begin errors++; $display("FAIL reset_thresh: got %0b expected 0", thresh_irq_o); end
        checks++; if (rts_no !== 1'b0) begin errors++; $display("FAIL reset_rts: got %0b expected 0", rts_no); end
        checks++; if ({rd_data_o, rd_parity_err_o, rd_stop_err_o} !== 10'h0) begin
            errors++; $display("FAIL reset_head: got %0h expected 0", {rd_data_o, rd_parity_err_o, rd_stop_err_o});
        end
    endtask

    task automatic test_single_push();
        do_reset();
        rx_valid = 1'b1; rx_data = 8'hA5; rx_perr = 1'b1; rx_serr = 1'b0;
        step();
        checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL push_count_edge: got %0d expected 1", count_o); end
        step();
        step();
        rx_valid = 1'b0;
        step();
        checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL push_held_count: got %0d expected 1", count_o); end
        checks++; if (rd_data_o !== 8'hA5) begin errors++; $display("FAIL push_data: got %0h expected a5", rd_data_o); end
        checks++; if (rd_parity_err_o !== 1'b1) begin errors++; $display("FAIL push_perr: got %0b expected 1", rd_parity_err_o); end
        checks++; if (rd_stop_err_o !== 1'b0) begin errors++; $display("FAIL push_serr: got %0b expected 0", rd_stop_err_o); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0, 1'(i % 2));
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full_o); end
        checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", count_o); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({rd_data_o, rd_stop_err_o} !== {8'(i), 1'(i % 2)}) begin
                errors++; $display("FAIL drain_order[%0d]: got %0h expected %0h", i, {rd_data_o, rd_stop_err_o}, {8'(i), 1'(i % 2)});
            end
            pop_char();
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", empty_o); end
        pop_char();
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL extra_pop_count: got %0d expected 0", count_o); end
        push_char(8'h77, 1'b0, 1'b1);
        checks++; if ({rd_data_o, rd_stop_err_o} !== {8'h77, 1'b1}) begin
            errors++; $display("FAIL wrap_head: got %0h expected %0h", {rd_data_o, rd_stop_err_o}, {8'h77, 1'b1});
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0, 1'b0);
        push_char(8'hFF, 1'b1, 1'b1);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b expected 1", overrun_o); end
        checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL ovr_count: got %0d expected 16", count_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL ovr_head: got %0h expected 0", rd_data_o); end
        ovclr = 1'b1; step(); ovclr = 1'b0;
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %0b expected 0", overrun_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0, 1'b0);
        rx_valid = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
        step();
        rx_valid = 1'b0; rd_en = 1'b0;
        step();
        checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL sim_full_count: got %0d expected 16", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL sim_full_ovr: got %0b expected 0", overrun_o); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (rd_data_o !== ((i == DEPTH) ? 8'h55 : 8'(i))) begin
                errors++; $display("FAIL sim_order[%0d]: got %0h expected %0h", i, rd_data_o, (i == DEPTH) ? 8'h55 : 8'(i));
            end
            pop_char();
        end
        rx_valid = 1'b1; rx_data = 8'h3C; rd_en = 1'b1;
        step();
        rx_valid = 1'b0; rd_en = 1'b0;
        checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL sim_empty_count: got %0d expected 1", count_o); end
        step();
        checks++; if (rd_data_o !== 8'h3C) begin errors++; $display("FAIL sim_empty_head: got %0h expected 3c", rd_data_o); end
    endtask

    task automatic test_threshold_flush_rts();
        do_reset();
        thr = 5'd4;
        for (int i = 0; i < 3; i++) push_char(8'(i), 1'b0, 1'b0);
        rx_valid = 1'b1; rx_data = 8'h03;
        step();
        rx_valid = 1'b0;
        checks++; if (thresh_irq_o !== 1'b0) begin errors++; $display("FAIL thr_lag: got %0b expected 0", thresh_irq_o); end
        step();
        checks++; if (thresh_irq_o !== 1'b1) begin errors++; $display("FAIL thr_set: got %0b expected 1", thresh_irq_o); end
        for (int i = 4; i < 13; i++) push_char(8'(i), 1'b0, 1'b0);
        checks++; if (rts_no !== 1'b0) begin errors++; $display("FAIL rts_13: got %0b expected 0", rts_no); end
        push_char(8'd13, 1'b0, 1'b0);
        checks++; if (rts_no !== RtsEn) begin errors++; $display("FAIL rts_14: got %0b expected %0b", rts_no, RtsEn); end
        for (int i = 14; i < 17; i++) push_char(8'(i), 1'b0, 1'b0);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL thr_ovr: got %0b expected 1", overrun_o); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %0b expected 1", empty_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL flush_ovr: got %0b expected 1", overrun_o); end
        step();
        checks++; if ({thresh_irq_o, rts_no} !== 2'b00) begin errors++; $display("FAIL flush_flags: got %0b expected 0", {thresh_irq_o, rts_no}); end
        ovclr = 1'b1; step(); ovclr = 1'b0;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        thr = 5'd4;
        for (int i = 0; i < 5; i++) push_char(8'(8'h40 + i), 1'b1, 1'b1);
        checks++; if (thresh_irq_o !== 1'b1) begin errors++; $display("FAIL mid_pre_thr: got %0b expected 1", thresh_irq_o); end
        rx_valid = 1'b1; rx_data = 8'h99;
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count_o); end
        checks++; if ({empty_o, full_o, overrun_o, thresh_irq_o, rts_no} !== 5'b10000) begin
            errors++; $display("FAIL mid_flags: got %05b expected 10000", {empty_o, full_o, overrun_o, thresh_irq_o, rts_no});
        end
        checks++; if ({rd_data_o, rd_parity_err_o, rd_stop_err_o} !== 10'h0) begin
            errors++; $display("FAIL mid_head: got %0h expected 0", {rd_data_o, rd_parity_err_o, rd_stop_err_o});
        end
        step();
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL mid_no_push: got %0d expected 0", count_o); end
        rx_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        int pop_pct;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            pop_pct  = ((i / 500) % 2 == 1) ? 15 : 45;
            reset    = ($urandom_range(0, 799) == 0);
            rx_valid = ($urandom_range(0, 99) < 60);
            rx_data  = 8'($urandom());
            rx_perr  = 1'($urandom());
            rx_serr  = 1'($urandom());
            rd_en    = ($urandom_range(0, 99) < pop_pct);
            flush    = ($urandom_range(0, 199) == 0);
            ovclr    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) thr = 5'($urandom_range(0, DEPTH));
            step();
            checks++; if (int'(count_o) !== mq.size()) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", i, count_o, mq.size()); end
            checks++; if (empty_o !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty@%0d: got %0b expected %0b", i, empty_o, mq.size() == 0); end
            checks++; if (full_o !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full@%0d: got %0b expected %0b", i, full_o, mq.size() == DEPTH); end
            checks++; if (overrun_o !== m_overrun) begin errors++; $display("FAIL rnd_ovr@%0d: got %0b expected %0b", i, overrun_o, m_overrun); end
            checks++; if (thresh_irq_o !== m_thr) begin errors++; $display("FAIL rnd_thr@%0d: got %0b expected %0b", i, thresh_irq_o, m_thr); end
            checks++; if (rts_no !== m_rts) begin errors++; $display("FAIL rnd_rts@%0d: got %0b expected %0b", i, rts_no, m_rts); end
            if (mq.size() > 0) begin
                checks++;
                if ({rd_data_o, rd_parity_err_o, rd_stop_err_o} !== mq[0]) begin
                    errors++; $display("FAIL rnd_head@%0d: got %0h expected %0h", i, {rd_data_o, rd_parity_err_o, rd_stop_err_o}, mq[0]);
                end
            end
        end
        reset = 1'b0; rx_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; ovclr = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_perr = 1'b0; rx_serr = 1'b0;
        rd_en = 1'b0; flush = 1'b0; ovclr = 1'b0; thr = '0;
        m_prev = 0; m_overrun = 0; m_thr = 0; m_rts = 0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_overrun();
        test_simultaneous();
        test_threshold_flush_rts();
        test_midstream_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
